// File: rtl/cache_pkg.sv
// cache_pkg: shared types, default sizes and the line-address helper for the writeback buffer
package cache_pkg;
    localparam int WBB_LINE_SIZE      = 64;
    localparam int WBB_ADDR_WIDTH     = 32;
    localparam int WBB_MEM_DATA_WIDTH = 64;
    localparam int WBB_DEPTH          = 2;
    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} wbb_state_t;
    typedef struct packed {
        logic [WBB_ADDR_WIDTH-1:0]  addr;
        logic [WBB_LINE_SIZE*8-1:0] data;
    } wb_entry_t;
    function automatic logic [63:0] line_addr(input logic [63:0] a, input int off_bits);
        return a & ~((64'd1 << off_bits) - 64'd1);
    endfunction
endpackage

// File: rtl/writeback_buffer_if.sv
// writeback_buffer_if: eviction input channel and memory write channels (aw/w/b)
interface writeback_buffer_if #(
    parameter int LINE_SIZE      = 64,
    parameter int ADDR_WIDTH     = 32,
    parameter int MEM_DATA_WIDTH = 64
);
    logic                      wb_valid;
    logic                      wb_ready;
    logic [ADDR_WIDTH-1:0]     wb_addr;
    logic [LINE_SIZE*8-1:0]    wb_data;
    logic                      mem_aw_valid;
    logic                      mem_aw_ready;
    logic [ADDR_WIDTH-1:0]     mem_aw_addr;
    logic                      mem_w_valid;
    logic                      mem_w_ready;
    logic [MEM_DATA_WIDTH-1:0] mem_w_data;
    logic                      mem_w_last;
    logic                      mem_b_valid;
    modport slave (
        input  wb_valid, wb_addr, wb_data, mem_aw_ready, mem_w_ready, mem_b_valid,
        output wb_ready, mem_aw_valid, mem_aw_addr, mem_w_valid, mem_w_data, mem_w_last
    );
    modport master (
        output wb_valid, wb_addr, wb_data, mem_aw_ready, mem_w_ready, mem_b_valid,
        input  wb_ready, mem_aw_valid, mem_aw_addr, mem_w_valid, mem_w_data, mem_w_last
    );
endinterface

// File: rtl/wbb_fifo.sv
// wbb_fifo: circular line-entry store with count; exposes all entries when WBB_SNOOP_EN is defined
module wbb_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 push_data,
    output logic [W-1:0]                 head,
    output logic                         full,
    output logic                         empty
`ifdef WBB_SNOOP_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [$clog2(DEPTH)-1:0]     rd_ptr,
    output logic [DEPTH-1:0][W-1:0]      entries
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    logic [DEPTH-1:0][W-1:0] mem;
    logic [PW-1:0]           wr, rd;
    logic [CW-1:0]           cnt;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr  <= '0;
            rd  <= '0;
            cnt <= '0;
        end else begin
            if (push) wr <= wr + 1'b1;
            if (pop) rd <= rd + 1'b1;
            if (push && !pop) cnt <= cnt + 1'b1;
            else if (pop && !push) cnt <= cnt - 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr] <= push_data;
    end
    assign head  = mem[rd];
    assign full  = cnt == CW'(DEPTH);
    assign empty = cnt == '0;
`ifdef WBB_SNOOP_EN
    assign count   = cnt;
    assign rd_ptr  = rd;
    assign entries = mem;
`endif
endmodule

// File: rtl/writeback_buffer.sv
// writeback_buffer: queues evicted lines and drains each as aw, BEATS w beats, then b.
// Optional WBB_SNOOP_EN adds a combinational lookup of buffered lines by address.
module writeback_buffer
    import cache_pkg::*;
#(
    parameter int LINE_SIZE      = WBB_LINE_SIZE,
    parameter int ADDR_WIDTH     = WBB_ADDR_WIDTH,
    parameter int MEM_DATA_WIDTH = WBB_MEM_DATA_WIDTH,
    parameter int DEPTH          = WBB_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    writeback_buffer_if.slave       bus,
    output logic                    empty,
    output logic                    full
`ifdef WBB_SNOOP_EN
    ,
    input  logic [ADDR_WIDTH-1:0]   snoop_addr,
    output logic                    snoop_hit,
    output logic [LINE_SIZE*8-1:0]  snoop_data
`endif
);
    localparam int LW    = LINE_SIZE * 8;
    localparam int BEATS = LW / MEM_DATA_WIDTH;
    localparam int BW    = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int OFF   = $clog2(LINE_SIZE);
    localparam int W     = ADDR_WIDTH + LW;
    wbb_state_t      state, state_next;
    logic [BW-1:0]   beat, beat_next;
    logic            push, pop, fifo_empty;
    logic [W-1:0]    head;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [LW-1:0]   head_data;
    assign bus.wb_ready = !full;
    assign push  = bus.wb_valid && !full;
    assign pop   = state == RESP && bus.mem_b_valid;
    assign empty = fifo_empty && state == IDLE;
    assign {head_addr, head_data} = head;
`ifdef WBB_SNOOP_EN
    localparam int PW = $clog2(DEPTH);
    logic [$clog2(DEPTH+1)-1:0] count;
    logic [PW-1:0]              rd_ptr;
    logic [DEPTH-1:0][W-1:0]    entries;
`endif
    wbb_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .push_data ({ADDR_WIDTH'(line_addr(64'(bus.wb_addr), OFF)), bus.wb_data}),
        .head      (head),
        .full      (full),
        .empty     (fifo_empty)
`ifdef WBB_SNOOP_EN
        ,
        .count     (count),
        .rd_ptr    (rd_ptr),
        .entries   (entries)
`endif
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            beat  <= '0;
        end else begin
            state <= state_next;
            beat  <= beat_next;
        end
    end
    // Address and data buses are forced to 0 outside their phase so idle outputs are deterministic.
    always_comb begin
        state_next       = state;
        beat_next        = beat;
        bus.mem_aw_valid = 1'b0;
        bus.mem_aw_addr  = '0;
        bus.mem_w_valid  = 1'b0;
        bus.mem_w_data   = '0;
        bus.mem_w_last   = 1'b0;
        case (state)
            IDLE: state_next = fifo_empty ? IDLE : ADDR;
            ADDR: begin
                bus.mem_aw_valid = 1'b1;
                bus.mem_aw_addr  = head_addr;
                state_next       = bus.mem_aw_ready ? DATA : ADDR;
                beat_next        = '0;
            end
            DATA: begin
                bus.mem_w_valid = 1'b1;
                bus.mem_w_data  = head_data[beat*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
                bus.mem_w_last  = beat == BW'(BEATS-1);
                beat_next       = bus.mem_w_ready ? beat + 1'b1 : beat;
                state_next      = bus.mem_w_ready && bus.mem_w_last ? RESP : DATA;
            end
            RESP: state_next = bus.mem_b_valid ? IDLE : RESP;
            default: state_next = IDLE;
        endcase
    end
`ifdef WBB_SNOOP_EN
    // Scan oldest to youngest so the last match (youngest) wins; the head stays counted until its b arrives.
    always_comb begin
        snoop_hit  = 1'b0;
        snoop_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i < int'(count) &&
                entries[rd_ptr + PW'(i)][W-1 -: ADDR_WIDTH] == ADDR_WIDTH'(line_addr(64'(snoop_addr), OFF))) begin
                snoop_hit  = 1'b1;
                snoop_data = entries[rd_ptr + PW'(i)][LW-1:0];
            end
        end
    end
`endif
endmodule

// File: tb/tb_writeback_buffer.sv
// tb_writeback_buffer: directed checks of enqueue, drain ordering, stalls, full/pop overlap and reset.
// Snoop checks are compiled in when WBB_SNOOP_EN is defined.
module tb_writeback_buffer;
    logic clk = 1'b0;
    logic rst_n;
    logic empty, full;
    int   n_chk = 0;
    int   n_fail = 0;
    int   last_wait;
    bit   acc;
    always #5 clk = ~clk;

    writeback_buffer_if #(.LINE_SIZE(64), .ADDR_WIDTH(32), .MEM_DATA_WIDTH(64)) bus ();
`ifdef WBB_SNOOP_EN
    logic [31:0]  snoop_addr;
    logic         snoop_hit;
    logic [511:0] snoop_data;
`endif
    writeback_buffer #(.LINE_SIZE(64), .ADDR_WIDTH(32), .MEM_DATA_WIDTH(64), .DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .empty (empty),
        .full  (full)
`ifdef WBB_SNOOP_EN
        ,
        .snoop_addr (snoop_addr),
        .snoop_hit  (snoop_hit),
        .snoop_data (snoop_data)
`endif
    );

    typedef struct {
        logic w_ready;
        int   beat;
        logic last;
    } vec_t;
    vec_t tbl[14];

    function automatic logic [511:0] mk_line(input logic [7:0] base);
        logic [511:0] l;
        for (int i = 0; i < 64; i++) l[8*i +: 8] = base + 8'(i);
        return l;
    endfunction

    function automatic logic [63:0] beat_of(input logic [7:0] base, input int b);
        logic [63:0] r;
        for (int j = 0; j < 8; j++) r[8*j +: 8] = base + 8'(8*b + j);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] addr, input logic [7:0] base, output bit a);
        bus.wb_valid = 1'b1;
        bus.wb_addr  = addr;
        bus.wb_data  = mk_line(base);
        @(negedge clk);
        a = bus.wb_ready;
        tick();
        bus.wb_valid = 1'b0;
    endtask

    task automatic wait_aw();
        int n = 0;
        @(negedge clk);
        while (!bus.mem_aw_valid && n < 20) begin
            tick();
            @(negedge clk);
            n++;
        end
        last_wait = n;
        check("aw_valid", 64'(bus.mem_aw_valid), 64'd1);
    endtask

    task automatic drain(input logic [31:0] addr, input logic [7:0] base, input bit do_resp);
        wait_aw();
        check("aw_addr", 64'(bus.mem_aw_addr), 64'(addr));
        tick();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("w_valid", 64'(bus.mem_w_valid), 64'd1);
            check("w_data", bus.mem_w_data, beat_of(base, k));
            check("w_last", 64'(bus.mem_w_last), 64'(k == 7));
            tick();
        end
        if (do_resp) begin
            @(negedge clk);
            check("resp_w_valid", 64'(bus.mem_w_valid), 64'd0);
            check("resp_empty", 64'(empty), 64'd0);
            tick();
            tick();
            bus.mem_b_valid = 1'b1;
            tick();
            bus.mem_b_valid = 1'b0;
        end
    endtask

    initial begin
        tbl[0]  = '{1'b0, 0, 1'b0};
        tbl[1]  = '{1'b1, 0, 1'b0};
        tbl[2]  = '{1'b1, 1, 1'b0};
        tbl[3]  = '{1'b0, 2, 1'b0};
        tbl[4]  = '{1'b0, 2, 1'b0};
        tbl[5]  = '{1'b1, 2, 1'b0};
        tbl[6]  = '{1'b0, 3, 1'b0};
        tbl[7]  = '{1'b1, 3, 1'b0};
        tbl[8]  = '{1'b1, 4, 1'b0};
        tbl[9]  = '{1'b0, 5, 1'b0};
        tbl[10] = '{1'b1, 5, 1'b0};
        tbl[11] = '{1'b1, 6, 1'b0};
        tbl[12] = '{1'b0, 7, 1'b1};
        tbl[13] = '{1'b1, 7, 1'b1};
        rst_n = 1'b0;
        bus.wb_valid = 1'b0;
        bus.wb_addr = '0;
        bus.wb_data = '0;
        bus.mem_aw_ready = 1'b1;
        bus.mem_w_ready = 1'b1;
        bus.mem_b_valid = 1'b0;
`ifdef WBB_SNOOP_EN
        snoop_addr = '0;
`endif
        repeat (3) tick();
        @(negedge clk);
        check("rst_wb_ready", 64'(bus.wb_ready), 64'd1);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_full", 64'(full), 64'd0);
        check("rst_aw_valid", 64'(bus.mem_aw_valid), 64'd0);
        check("rst_w_valid", 64'(bus.mem_w_valid), 64'd0);
        check("rst_aw_addr", 64'(bus.mem_aw_addr), 64'd0);
        check("rst_w_data", bus.mem_w_data, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // single line, offset bits dropped, earliest presentation two cycles after enqueue
        push(32'h1000_0047, 8'h00, acc);
        check("t1_accept", 64'(acc), 64'd1);
        @(negedge clk);
        check("t1_aw_early", 64'(bus.mem_aw_valid), 64'd0);
        check("t1_busy", 64'(empty), 64'd0);
        tick();
        drain(32'h1000_0040, 8'h00, 1'b1);
        check("t1_aw_latency", 64'(last_wait), 64'd0);
        @(negedge clk);
        check("t1_empty", 64'(empty), 64'd1);
        tick();

        // two lines with aw held off: buffer fills, third refused, FIFO order
        bus.mem_aw_ready = 1'b0;
        push(32'h1000_1000, 8'h20, acc);
        check("t2_acc_a", 64'(acc), 64'd1);
        push(32'h1000_2000, 8'h60, acc);
        check("t2_acc_b", 64'(acc), 64'd1);
        @(negedge clk);
        check("t2_full", 64'(full), 64'd1);
        check("t2_wb_ready", 64'(bus.wb_ready), 64'd0);
        check("t2_aw_hold", 64'(bus.mem_aw_addr), 64'h1000_1000);
        tick();
        push(32'h1000_3000, 8'hA0, acc);
        check("t2_acc_c", 64'(acc), 64'd0);
        @(negedge clk);
        check("t2_aw_stable", 64'(bus.mem_aw_addr), 64'h1000_1000);
        tick();
        bus.mem_aw_ready = 1'b1;
        drain(32'h1000_1000, 8'h20, 1'b1);
        drain(32'h1000_2000, 8'h60, 1'b1);
        @(negedge clk);
        check("t2_empty", 64'(empty), 64'd1);
        tick();

        // w_ready stall pattern from the table
        push(32'h2000_0000, 8'h40, acc);
        check("t3_accept", 64'(acc), 64'd1);
        wait_aw();
        check("t3_aw_addr", 64'(bus.mem_aw_addr), 64'h2000_0000);
        tick();
        for (int i = 0; i < 14; i++) begin
            bus.mem_w_ready = tbl[i].w_ready;
            @(negedge clk);
            check("t3_w_valid", 64'(bus.mem_w_valid), 64'd1);
            check("t3_w_data", bus.mem_w_data, beat_of(8'h40, tbl[i].beat));
            check("t3_w_last", 64'(bus.mem_w_last), 64'(tbl[i].last));
            tick();
        end
        bus.mem_w_ready = 1'b1;
        @(negedge clk);
        check("t3_resp_w_valid", 64'(bus.mem_w_valid), 64'd0);
        tick();
        bus.mem_b_valid = 1'b1;
        tick();
        bus.mem_b_valid = 1'b0;
        @(negedge clk);
        check("t3_empty", 64'(empty), 64'd1);
        tick();

        // push while full in the same cycle as the head retires
        push(32'h5000_0000, 8'h00, acc);
        check("t4_acc_a", 64'(acc), 64'd1);
        push(32'h5000_0040, 8'hC0, acc);
        check("t4_acc_b", 64'(acc), 64'd1);
        drain(32'h5000_0000, 8'h00, 1'b0);
        bus.wb_valid = 1'b1;
        bus.wb_addr = 32'h5000_0080;
        bus.wb_data = mk_line(8'hE0);
        bus.mem_b_valid = 1'b1;
        @(negedge clk);
        check("t4_ready_while_pop", 64'(bus.wb_ready), 64'd0);
        check("t4_full_while_pop", 64'(full), 64'd1);
        tick();
        bus.wb_valid = 1'b0;
        bus.mem_b_valid = 1'b0;
        @(negedge clk);
        check("t4_full_after", 64'(full), 64'd0);
        check("t4_ready_after", 64'(bus.wb_ready), 64'd1);
        check("t4_not_empty", 64'(empty), 64'd0);
        tick();
        drain(32'h5000_0040, 8'hC0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_no_extra_aw", 64'(bus.mem_aw_valid), 64'd0);
            check("t4_empty", 64'(empty), 64'd1);
            tick();
        end

        // reset during beat 3
        push(32'h3000_0010, 8'h80, acc);
        check("t5_accept", 64'(acc), 64'd1);
        wait_aw();
        check("t5_aw_addr", 64'(bus.mem_aw_addr), 64'h3000_0000);
        tick();
        repeat (3) tick();
        @(negedge clk);
        check("t5_beat3", bus.mem_w_data, beat_of(8'h80, 3));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_w_valid", 64'(bus.mem_w_valid), 64'd0);
        check("t5_empty", 64'(empty), 64'd1);
        check("t5_wb_ready", 64'(bus.wb_ready), 64'd1);
        tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t5_idle_w", 64'(bus.mem_w_valid), 64'd0);
            check("t5_idle_aw", 64'(bus.mem_aw_valid), 64'd0);
            tick();
        end

`ifdef WBB_SNOOP_EN
        // two copies of one line: youngest data returned, miss after both retire
        bus.mem_aw_ready = 1'b0;
        push(32'h4000_0080, 8'h10, acc);
        check("t6_acc_a", 64'(acc), 64'd1);
        push(32'h4000_0080, 8'h90, acc);
        check("t6_acc_b", 64'(acc), 64'd1);
        snoop_addr = 32'h4000_00A5;
        @(negedge clk);
        check("t6_hit", 64'(snoop_hit), 64'd1);
        check("t6_data_young", 64'(snoop_data == mk_line(8'h90)), 64'd1);
        tick();
        snoop_addr = 32'h4000_00C0;
        @(negedge clk);
        check("t6_other_miss", 64'(snoop_hit), 64'd0);
        tick();
        snoop_addr = 32'h4000_0080;
        bus.mem_aw_ready = 1'b1;
        drain(32'h4000_0080, 8'h10, 1'b1);
        drain(32'h4000_0080, 8'h90, 1'b1);
        @(negedge clk);
        check("t6_miss_after", 64'(snoop_hit), 64'd0);
        check("t6_empty", 64'(empty), 64'd1);
        tick();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
